// File: rtl/mod_inverse.sv
// Sequential modular inverter: a^-1 mod Q computed as a^(Q-2) mod Q by
// MSB-first square-and-multiply, one modular multiply per clock.
module mod_inverse #(
    parameter int WIDTH    = 32,
    parameter int Q        = 3329,
    parameter int EXP_BITS = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    localparam int                 IDX_W   = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
    localparam logic [EXP_BITS-1:0] EXP    = EXP_BITS'(Q - 2);
    localparam logic [WIDTH-1:0]   Q_N     = WIDTH'(Q);
    localparam logic [2*WIDTH-1:0] Q_W     = (2 * WIDTH)'(Q);
    localparam logic [IDX_W-1:0]   IDX_MSB = IDX_W'(EXP_BITS - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    typedef enum logic {SQ, MUL} phase_t;

    state_t             state_q, state_d;
    phase_t             phase_q, phase_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   base_q, base_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [WIDTH-1:0]   mul_op;
    logic [2*WIDTH-1:0] prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            phase_q   <= SQ;
            acc_q     <= '0;
            base_q    <= '0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            acc_q     <= acc_d;
            base_q    <= base_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        acc_d     = acc_q;
        base_d    = base_q;
        bit_idx_d = bit_idx_q;

        // The multiply step always runs (by 1 when the exponent bit is clear)
        // so the latency never depends on the operand.
        if (phase_q == SQ) begin
            mul_op = acc_q;
        end else begin
            mul_op = EXP[bit_idx_q] ? base_q : WIDTH'(1);
        end
        prod = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, mul_op};

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    base_d    = in_data % Q_N;
                    acc_d     = WIDTH'(1);
                    bit_idx_d = IDX_MSB;
                    phase_d   = SQ;
                    state_d   = CALC;
                end
            end
            CALC: begin
                acc_d = WIDTH'(prod % Q_W);
                if (phase_q == SQ) begin
                    phase_d = MUL;
                end else if (bit_idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    bit_idx_d = bit_idx_q - IDX_W'(1);
                    phase_d   = SQ;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_valid ? acc_q : '0;
    assign out_zero  = out_valid && (base_q == '0);

endmodule
